// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and instruction fetch sequencer with a 2-entry decode buffer
module fetch_sequencer #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_target,
   input  logic                  halt,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] instr_pc,
   input  logic                  instr_ready
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_KILL = 2'd3;

   localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

   logic [1:0]            state;
   logic [1:0]            state_next;
   logic [DATA_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] req_pc;
   logic [DATA_WIDTH-1:0] slot0_instr;
   logic [DATA_WIDTH-1:0] slot0_pc;
   logic [DATA_WIDTH-1:0] slot1_instr;
   logic [DATA_WIDTH-1:0] slot1_pc;
   logic [1:0]            buf_count;
   logic [1:0]            count_next;
   logic [1:0]            wr_idx;
   logic                  push;
   logic                  pop;
   logic                  issue_ok;
   logic                  issue_after;
   logic                  gnt_taken;
   logic [DATA_WIDTH-1:0] target_aligned;

   assign target_aligned = redirect_target & ALIGN_MASK;
   assign pop            = instr_valid && instr_ready;
   // A response arriving together with a redirect belongs to the wrong path.
   assign push           = (state == S_WAIT) && imem_rvalid && !redirect_valid;
   assign count_next     = redirect_valid ? 2'd0 : (buf_count + {1'b0, push} - {1'b0, pop});
   assign wr_idx         = buf_count - {1'b0, pop};
   assign issue_ok       = !halt && (buf_count < 2'd2);
   assign issue_after    = !halt && (count_next < 2'd2);
   assign gnt_taken      = (state == S_REQ) && imem_gnt;

   assign imem_req    = (state == S_REQ);
   assign imem_addr   = pc;
   assign instr_valid = (buf_count != 2'd0);
   assign instr       = slot0_instr;
   assign instr_pc    = slot0_pc;

   always_comb begin
      state_next = state;
      if (redirect_valid) begin
         case (state)
            S_IDLE:  state_next = halt ? S_IDLE : S_REQ;
            S_REQ:   state_next = imem_gnt ? S_KILL : S_REQ;
            default: state_next = imem_rvalid ? (halt ? S_IDLE : S_REQ) : S_KILL;
         endcase
      end else begin
         case (state)
            S_IDLE:  if (issue_ok) state_next = S_REQ;
            S_REQ:   if (imem_gnt) state_next = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_next = issue_after ? S_REQ : S_IDLE;
            default: if (imem_rvalid) state_next = halt ? S_IDLE : S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         pc     <= RESET_PC;
         req_pc <= '0;
      end else begin
         state <= state_next;
         if (redirect_valid) begin
            pc <= target_aligned;
         end else if (gnt_taken) begin
            req_pc <= pc;
            pc     <= pc + PC_STEP;
         end
      end
   end

   // Slot 0 is always the head; a pop shifts slot 1 down before the push lands.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_count   <= 2'd0;
         slot0_instr <= '0;
         slot0_pc    <= '0;
         slot1_instr <= '0;
         slot1_pc    <= '0;
      end else begin
         buf_count <= count_next;
         if (!redirect_valid) begin
            if (pop) begin
               slot0_instr <= slot1_instr;
               slot0_pc    <= slot1_pc;
            end
            if (push) begin
               if (wr_idx == 2'd0) begin
                  slot0_instr <= imem_rdata;
                  slot0_pc    <= req_pc;
               end else begin
                  slot1_instr <= imem_rdata;
                  slot1_pc    <= req_pc;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         assert (!(push && !pop && (buf_count == 2'd2)));
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        halt;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_sequencer #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .halt            (halt),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_gnt        (imem_gnt),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .instr_valid     (instr_valid),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_ready     (instr_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic cb(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic cw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; redirect_valid = 1'b0; redirect_target = '0; halt = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
      repeat (3) cycle();
      cb("rst_req", imem_req, 1'b0);
      cw("rst_addr", imem_addr, 32'h0);
      cb("rst_valid", instr_valid, 1'b0);
      cw("rst_instr", instr, 32'h0);
      cw("rst_ipc", instr_pc, 32'h0);

      rst = 1'b1; instr_ready = 1'b1; imem_gnt = 1'b1;
      cb("idle_req", imem_req, 1'b0);
      cycle();
      for (int i = 0; i < 4; i++) begin
         cb("seq_req", imem_req, 1'b1);
         cw("seq_addr", imem_addr, 32'(4 * i));
         cycle();
         cb("seq_wait_req", imem_req, 1'b0);
         cb("seq_popped", instr_valid, 1'b0);
         imem_rvalid = 1'b1; imem_rdata = mk(32'(4 * i));
         cycle();
         cb("seq_valid", instr_valid, 1'b1);
         cw("seq_instr", instr, mk(32'(4 * i)));
         cw("seq_ipc", instr_pc, 32'(4 * i));
         imem_rvalid = 1'b0;
      end

      // redirect while waiting; stale response arrives in KILL
      cycle();
      redirect_valid = 1'b1; redirect_target = 32'h100; imem_gnt = 1'b0;
      cycle();
      cb("kill_req", imem_req, 1'b0);
      cw("kill_addr", imem_addr, 32'h100);
      redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = mk(32'h10);
      cycle();
      cb("kill_drop", instr_valid, 1'b0);
      cb("kill_req2", imem_req, 1'b1);
      cw("kill_addr2", imem_addr, 32'h100);
      imem_rvalid = 1'b0; imem_gnt = 1'b1;
      cycle();
      imem_rvalid = 1'b1; imem_rdata = mk(32'h100);
      cycle();
      cw("redir_ipc", instr_pc, 32'h100);
      cw("redir_instr", instr, mk(32'h100));
      cw("redir_next_addr", imem_addr, 32'h104);

      // redirect coincides with rvalid and pop while one entry is buffered
      imem_rvalid = 1'b0; instr_ready = 1'b0;
      cycle();
      cb("s3_hold", instr_valid, 1'b1);
      instr_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = mk(32'h104);
      redirect_valid = 1'b1; redirect_target = 32'h200; imem_gnt = 1'b0;
      cycle();
      cb("s3_flush", instr_valid, 1'b0);
      cb("s3_req", imem_req, 1'b1);
      cw("s3_addr", imem_addr, 32'h200);
      redirect_valid = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b1;
      cycle();
      imem_rvalid = 1'b1; imem_rdata = mk(32'h200);
      cycle();
      cw("s3_ipc", instr_pc, 32'h200);

      // decode stalls for 10 cycles: buffer fills to 2 and fetch stops
      imem_rvalid = 1'b0; instr_ready = 1'b0;
      cycle();
      imem_rvalid = 1'b1; imem_rdata = mk(32'h204);
      cycle();
      imem_rvalid = 1'b0;
      cb("s4_req", imem_req, 1'b0);
      cw("s4_ipc", instr_pc, 32'h200);
      for (int k = 0; k < 8; k++) begin
         cycle();
         cb("s4_stall_req", imem_req, 1'b0);
      end
      cb("s4_still_valid", instr_valid, 1'b1);
      cw("s4_head", instr_pc, 32'h200);
      instr_ready = 1'b1;
      cycle();
      cw("s4_second", instr_pc, 32'h204);
      cw("s4_instr2", instr, mk(32'h204));
      cycle();
      cb("s4_resume", imem_req, 1'b1);
      cw("s4_resume_addr", imem_addr, 32'h208);
      cb("s4_empty", instr_valid, 1'b0);

      // pc wrap and target alignment
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC; imem_gnt = 1'b0;
      cycle();
      cb("wrap_req", imem_req, 1'b1);
      cw("wrap_top", imem_addr, 32'hFFFF_FFFC);
      redirect_valid = 1'b0; imem_gnt = 1'b1;
      cycle();
      cw("wrap_addr", imem_addr, 32'h0);
      imem_rvalid = 1'b1; imem_rdata = mk(32'hFFFF_FFFC); imem_gnt = 1'b0;
      cycle();
      cw("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
      cb("wrap_req2", imem_req, 1'b1);
      cw("wrap_addr2", imem_addr, 32'h0);
      imem_rvalid = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h103;
      cycle();
      cw("align_addr", imem_addr, 32'h100);
      cb("align_req", imem_req, 1'b1);
      cb("align_flush", instr_valid, 1'b0);
      redirect_valid = 1'b0; halt = 1'b1;

      // halt with grant delayed 3 cycles
      for (int k = 0; k < 3; k++) begin
         cycle();
         cb("halt_req_held", imem_req, 1'b1);
         cw("halt_addr_held", imem_addr, 32'h100);
      end
      imem_gnt = 1'b1;
      cycle();
      cb("halt_wait_req", imem_req, 1'b0);
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = mk(32'h100);
      cycle();
      cb("halt_valid", instr_valid, 1'b1);
      cw("halt_ipc", instr_pc, 32'h100);
      cb("halt_idle", imem_req, 1'b0);
      imem_rvalid = 1'b0;
      cycle();
      cycle();
      cb("halt_idle_req", imem_req, 1'b0);
      cb("halt_drained", instr_valid, 1'b0);
      cw("halt_pc", imem_addr, 32'h104);
      halt = 1'b0;
      cycle();
      cb("unhalt_req", imem_req, 1'b1);
      cw("unhalt_addr", imem_addr, 32'h104);

      // mid-operation reset with a fetch outstanding
      imem_gnt = 1'b1;
      cycle();
      rst = 1'b0;
      #2;
      cb("mrst_req", imem_req, 1'b0);
      cw("mrst_addr", imem_addr, 32'h0);
      cb("mrst_valid", instr_valid, 1'b0);
      imem_gnt = 1'b0;
      cycle();
      rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = mk(32'h104);
      cycle();
      imem_rvalid = 1'b0;
      cb("post_rst_req", imem_req, 1'b1);
      cw("post_rst_addr", imem_addr, 32'h0);
      cb("post_rst_valid", instr_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
